// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Contents:
//   ctr_t      - 2-bit saturating prediction counter state
//   CTR_RESET  - counter value loaded into every BHT entry on reset
//   ctr_next() - saturating counter step for a resolved branch outcome
package branch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WEAK_NT;

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        case (ctr)
            STRONG_NT: if (taken) nxt = WEAK_NT;  else nxt = STRONG_NT;
            WEAK_NT:   if (taken) nxt = WEAK_T;   else nxt = STRONG_NT;
            WEAK_T:    if (taken) nxt = STRONG_T; else nxt = WEAK_NT;
            default:   if (taken) nxt = STRONG_T; else nxt = WEAK_T;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-side bus of the branch prediction unit.
//   IF lookup : if_pc -> if_pred_taken, if_pred_target
//   EX resolve: ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_cond,
//               ex_pred_taken, ex_pred_target
//               -> pc_imm, pc_four, redirect, redirect_pc
// Modports: master = pipeline driving the unit, slave = the unit itself.
interface branch_predict_unit_if #(
    parameter int PC_W = 9
) ();

    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;
    logic [PC_W-1:0] if_pred_target;

    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_imm;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_cond;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;

    logic [31:0]     pc_imm;
    logic [31:0]     pc_four;
    logic            redirect;
    logic [31:0]     redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_cond,
               ex_pred_taken, ex_pred_target,
        input  if_pred_taken, if_pred_target, pc_imm, pc_four, redirect,
               redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump, ex_cond,
               ex_pred_taken, ex_pred_target,
        output if_pred_taken, if_pred_target, pc_imm, pc_four, redirect,
               redirect_pc
    );

endinterface

// File: rtl/branch_predict_unit_bht.sv
// Branch history table storage: register array of {ctr, valid, target}.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   rd_idx -> rd_ctr/rd_valid/rd_target - combinational lookup port
//   we, wr_idx, wr_ctr       - synchronous write of the counter
//   wr_set_valid, wr_tgt_en, wr_target - optional valid set / target write
//   wr_cur_ctr               - current counter at wr_idx, for read-modify-write
// Reset loads CTR_RESET, valid=0, target=0 in every entry and wins over a write.
module bht_mem
    import branch_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  PC_W  = 9,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    output logic             rd_valid,
    output logic [PC_W-1:0]  rd_target,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  ctr_t             wr_ctr,
    input  logic             wr_set_valid,
    input  logic             wr_tgt_en,
    input  logic [PC_W-1:0]  wr_target,
    output ctr_t             wr_cur_ctr
);

    ctr_t             ctr_q    [DEPTH];
    ctr_t             ctr_d    [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [PC_W-1:0]  target_q [DEPTH];
    logic [PC_W-1:0]  target_d [DEPTH];

    assign rd_ctr     = ctr_q[rd_idx];
    assign rd_valid   = valid_q[rd_idx];
    assign rd_target  = target_q[rd_idx];
    assign wr_cur_ctr = ctr_q[wr_idx];

    always_comb begin
        ctr_d    = ctr_q;
        valid_d  = valid_q;
        target_d = target_q;
        if (we) begin
            ctr_d[wr_idx] = wr_ctr;
            if (wr_set_valid) valid_d[wr_idx]  = 1'b1;
            if (wr_tgt_en)    target_d[wr_idx] = wr_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q    <= '{default: CTR_RESET};
            valid_q  <= '0;
            target_q <= '{default: '0};
        end else begin
            ctr_q    <= ctr_d;
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BHT lookup at IF, resolve and
// mispredict redirect at EX, BHT training on resolved branches/jumps.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - branch_predict_unit_if.slave (IF lookup + EX resolve)
//   perf_branches, perf_mispredicts - 32-bit event counters, present only
//                when BRANCH_PERF_CNT_EN is defined
// Parameters: PC_W (PC/target width), BHT_DEPTH (entries, power of 2);
// IDX_W is derived. Index is pc[IDX_W+1:2] for lookup and update.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int  PC_W      = 9,
    parameter int  BHT_DEPTH = 16,
    localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_unit_if.slave bus
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_branches,
    output logic [31:0]          perf_mispredicts
`endif
);

    ctr_t            rd_ctr;
    logic            rd_valid;
    logic [PC_W-1:0] rd_target;
    ctr_t            cur_ctr;
    ctr_t            wr_ctr;
    logic [31:0]     pc_ext;
    logic [31:0]     pc_imm;
    logic [31:0]     pc_four;
    logic            act_taken;
    logic            redirect;
    logic            upd;
    logic            alias_upd;

    bht_mem #(
        .DEPTH (BHT_DEPTH),
        .PC_W  (PC_W)
    ) u_bht (
        .clk          (clk),
        .reset        (reset),
        .rd_idx       (bus.if_pc[IDX_W+1:2]),
        .rd_ctr       (rd_ctr),
        .rd_valid     (rd_valid),
        .rd_target    (rd_target),
        .we           (upd | alias_upd),
        .wr_idx       (bus.ex_pc[IDX_W+1:2]),
        .wr_ctr       (wr_ctr),
        .wr_set_valid (upd),
        .wr_tgt_en    (upd & act_taken),
        .wr_target    (pc_imm[PC_W-1:0]),
        .wr_cur_ctr   (cur_ctr)
    );

    // Lookup reads the registered table only: a same-cycle update is not bypassed.
    assign bus.if_pred_taken  = rd_valid & rd_ctr[1];
    assign bus.if_pred_target = rd_valid ? rd_target : '0;

    assign pc_ext    = {{(32-PC_W){1'b0}}, bus.ex_pc};
    assign pc_imm    = pc_ext + bus.ex_imm;
    assign pc_four   = pc_ext + 32'd4;
    assign act_taken = bus.ex_valid & ((bus.ex_branch & bus.ex_cond) | bus.ex_jump);

    // Including ex_pred_taken catches a non-branch aliased onto a taken entry.
    assign redirect = bus.ex_valid
                    & (bus.ex_branch | bus.ex_jump | bus.ex_pred_taken)
                    & ((act_taken != bus.ex_pred_taken)
                       | (act_taken & (pc_imm[PC_W-1:0] != bus.ex_pred_target)));

    assign bus.pc_imm      = pc_imm;
    assign bus.pc_four     = pc_four;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = act_taken ? pc_imm : pc_four;

    assign upd       = bus.ex_valid & (bus.ex_branch | bus.ex_jump);
    assign alias_upd = bus.ex_valid & ~(bus.ex_branch | bus.ex_jump) & bus.ex_pred_taken;

    always_comb begin
        wr_ctr = cur_ctr;
        if (bus.ex_jump)        wr_ctr = STRONG_T;
        else if (bus.ex_branch) wr_ctr = ctr_next(cur_ctr, act_taken);
        else                    wr_ctr = ctr_next(cur_ctr, 1'b0);
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_branches_d;
    logic [31:0] perf_mispredicts_q;
    logic [31:0] perf_mispredicts_d;

    always_comb begin
        perf_branches_d    = perf_branches_q + {31'b0, upd};
        perf_mispredicts_d = perf_mispredicts_q + {31'b0, redirect};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (PC_W=9, BHT_DEPTH=16).
// One vector per clock cycle: inputs driven #1 after posedge, expected
// outputs queued, then popped and compared on the following negedge.
// Exercises perf counters too when BRANCH_PERF_CNT_EN is defined.
module tb_branch_predict_unit;

    localparam int PC_W = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.PC_W(PC_W)) bus ();

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    branch_predict_unit #(
        .PC_W      (PC_W),
        .BHT_DEPTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    typedef struct {
        logic            rst;
        logic [PC_W-1:0] if_pc;
        logic            ev;
        logic [PC_W-1:0] epc;
        logic [31:0]     imm;
        logic            br;
        logic            jp;
        logic            cond;
        logic            ptk;
        logic [PC_W-1:0] ptgt;
        logic            chk;
        logic            e_ptk;
        logic [PC_W-1:0] e_ptgt;
        logic            e_red;
        logic [31:0]     e_rpc;
    } vec_t;

    typedef struct {
        string           name;
        logic            chk;
        logic            e_ptk;
        logic [PC_W-1:0] e_ptgt;
        logic            e_red;
        logic [31:0]     e_rpc;
        logic            chk_sum;
        logic [31:0]     e_pimm;
        logic [31:0]     e_pfour;
        logic            upd;
        logic            rst;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_br = 0;
    int   exp_mp = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic [PC_W-1:0] if_pc, input logic ev,
        input logic [PC_W-1:0] epc, input logic [31:0] imm, input logic br,
        input logic jp, input logic cond, input logic ptk,
        input logic [PC_W-1:0] ptgt, input logic e_ptk,
        input logic [PC_W-1:0] e_ptgt, input logic e_red, input logic [31:0] e_rpc);
        vec_t v;
        v.rst = rst; v.if_pc = if_pc; v.ev = ev; v.epc = epc; v.imm = imm;
        v.br = br; v.jp = jp; v.cond = cond; v.ptk = ptk; v.ptgt = ptgt;
        v.chk = 1'b1; v.e_ptk = e_ptk; v.e_ptgt = e_ptgt; v.e_red = e_red;
        v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name, input logic chk_sum,
                         input logic [31:0] pimm, input logic [31:0] pfour);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        reset              = v.rst;
        bus.if_pc          = v.if_pc;
        bus.ex_valid       = v.ev;
        bus.ex_pc          = v.epc;
        bus.ex_imm         = v.imm;
        bus.ex_branch      = v.br;
        bus.ex_jump        = v.jp;
        bus.ex_cond        = v.cond;
        bus.ex_pred_taken  = v.ptk;
        bus.ex_pred_target = v.ptgt;
        e.name = name; e.chk = v.chk; e.e_ptk = v.e_ptk; e.e_ptgt = v.e_ptgt;
        e.e_red = v.e_red; e.e_rpc = v.e_rpc; e.chk_sum = chk_sum;
        e.e_pimm = pimm; e.e_pfour = pfour;
        e.upd = v.ev & (v.br | v.jp); e.rst = v.rst;
        sb_q.push_back(e);

        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL %s: scoreboard empty, got nothing, required an entry", name);
        end else begin
            got = sb_q.pop_front();
            if (got.chk) begin
                cmp({got.name, " pred_taken"},  {31'b0, bus.if_pred_taken},  {31'b0, got.e_ptk});
                cmp({got.name, " pred_target"}, {23'b0, bus.if_pred_target}, {23'b0, got.e_ptgt});
                cmp({got.name, " redirect"},    {31'b0, bus.redirect},       {31'b0, got.e_red});
                cmp({got.name, " redirect_pc"}, bus.redirect_pc,             got.e_rpc);
`ifdef BRANCH_PERF_CNT_EN
                cmp({got.name, " perf_branches"},    perf_branches,    exp_br);
                cmp({got.name, " perf_mispredicts"}, perf_mispredicts, exp_mp);
`endif
            end
            if (got.chk_sum) begin
                cmp({got.name, " pc_imm"},  bus.pc_imm,  got.e_pimm);
                cmp({got.name, " pc_four"}, bus.pc_four, got.e_pfour);
            end
            // Counter model: value seen at the next sample reflects this cycle's edge.
            if (got.rst) begin
                exp_br = 0;
                exp_mp = 0;
            end else begin
                exp_br += int'(got.upd);
                exp_mp += int'(got.e_red);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[23];
        vec_t h[7];

        // rst if_pc ev epc imm br jp cond ptk ptgt | e_ptk e_ptgt e_red e_rpc
        tbl[0]  = mk(1, 'h010, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);
        tbl[0].chk = 1'b0;
        tbl[1]  = mk(1, 'h010, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);
        tbl[2]  = mk(0, 'h010, 1, 'h010, 'h20,       1, 0, 1, 0, 'h000, 0, 'h000, 1, 'h30);
        tbl[3]  = mk(0, 'h010, 1, 'h010, 'h20,       1, 0, 1, 1, 'h030, 1, 'h030, 0, 'h30);
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = mk(0, 'h010, 1, 'h010, 'h20,       1, 0, 0, 1, 'h030, 1, 'h030, 1, 'h14);
        tbl[7]  = mk(0, 'h010, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 1, 'h030, 0, 'h04);
        tbl[8]  = mk(0, 'h040, 1, 'h040, 'hFFFFFFF0, 0, 1, 0, 0, 'h000, 0, 'h000, 1, 'h30);
        tbl[9]  = mk(0, 'h040, 1, 'h040, 'hFFFFFFF0, 0, 1, 0, 1, 'h030, 1, 'h030, 0, 'h30);
        tbl[10] = mk(0, 'h040, 1, 'h040, 'hFFFFFFF0, 0, 1, 0, 1, 'h044, 1, 'h030, 1, 'h30);
        tbl[11] = mk(0, 'h044, 1, 'h004, 'h8,        1, 0, 1, 0, 'h000, 0, 'h000, 1, 'h0C);
        tbl[12] = mk(0, 'h044, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 1, 'h00C, 0, 'h04);
        tbl[13] = mk(0, 'h044, 1, 'h044, 'h8,        0, 0, 0, 1, 'h00C, 1, 'h00C, 1, 'h48);
        tbl[14] = mk(0, 'h004, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h00C, 0, 'h04);
        tbl[15] = mk(0, 'h008, 1, 'h008, 'h10,       1, 0, 1, 0, 'h000, 0, 'h000, 1, 'h18);
        tbl[16] = mk(0, 'h008, 1, 'h008, 'h10,       1, 0, 1, 1, 'h018, 1, 'h018, 0, 'h18);
        tbl[17] = mk(1, 'h008, 1, 'h008, 'h10,       1, 0, 0, 1, 'h018, 1, 'h018, 1, 'h0C);
        tbl[18] = mk(0, 'h008, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);
        tbl[19] = mk(0, 'h010, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);
        tbl[20] = mk(0, 'h040, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);
        tbl[21] = mk(0, 'h010, 0, 'h010, 'h20,       1, 0, 1, 1, 'h099, 0, 'h000, 0, 'h14);
        tbl[22] = mk(0, 'h010, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);

        for (int unsigned i = 0; i < 23; i++)
            apply(tbl[i], $sformatf("row%0d", i), 1'b0, '0, '0);

        // Counter saturation at STRONG_NT on idx 3, then 32-bit sum wrap, then reset.
        h[0] = mk(0, 'h00C, 1, 'h00C, 'h100,      1, 0, 0, 0, 'h000, 0, 'h000, 0, 'h10);
        h[1] = h[0];
        h[2] = mk(0, 'h00C, 1, 'h00C, 'h100,      1, 0, 1, 0, 'h000, 0, 'h000, 1, 'h10C);
        h[3] = mk(0, 'h00C, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h10C, 0, 'h04);
        h[4] = mk(0, 'h00C, 0, 'h1FC, 'hFFFFFE08, 1, 0, 1, 0, 'h000, 0, 'h10C, 0, 'h200);
        h[5] = mk(1, 'h00C, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h10C, 0, 'h04);
        h[6] = mk(0, 'h00C, 0, 'h000, 'h0,        0, 0, 0, 0, 'h000, 0, 'h000, 0, 'h04);

        apply(h[0], "sat_nt_a", 1'b1, 32'h10C, 32'h10);
        apply(h[1], "sat_nt_b", 1'b0, '0, '0);
        apply(h[2], "sat_nt_up", 1'b0, '0, '0);
        apply(h[3], "sat_nt_look", 1'b0, '0, '0);
        apply(h[4], "sum_wrap", 1'b1, 32'h4, 32'h200);
        apply(h[5], "final_rst", 1'b0, '0, '0);
        apply(h[6], "after_rst", 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
